bc_sum_assembler: RTL
=====================

BC_SUM_ASSEMBLER -- requirements
Module: bc_sum_assembler

Interface
REQ-001 Parameter NIB, default 4, is the number of 4-bit slices per assembled word; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  a slice is presented on in_sum/in_cout/in_first this cycle.
REQ-005 in_ready  output  1  the block can accept the presented slice; transfer occurs when in_valid && in_ready.
REQ-006 in_sum  input  4  registered 4-bit sum slice from the upstream 4-bit adder stage, LSB slice first.
REQ-007 in_cout  input  1  registered carry-out accompanying in_sum.
REQ-008 in_first  input  1  marks the presented slice as slice 0 of a new word.
REQ-009 out_valid  output  1  out_data/out_carry hold a completed word.
REQ-010 out_ready  input  1  downstream accepts the word; transfer when out_valid && out_ready.
REQ-011 out_data  output  4*NIB  assembled word; slice k occupies bits [4k+3:4k].
REQ-012 out_carry  output  1  in_cout of the final slice of the word.
REQ-013 sync_err  output  1  one-cycle pulse: partial word discarded by in_first.
REQ-014 word_cnt  output  8  count of words delivered on the output handshake.

Function
REQ-015 Internal slice index idx (0..NIB-1) selects the collect-register field written by each accepted slice.
REQ-016 States: COLLECT (output slot empty) and HOLD (output slot full, out_valid=1).
REQ-017 Accepted slice with in_first=1: written to field 0; idx becomes 1; if idx was nonzero, sync_err=1 next cycle and the old partial word is lost.
REQ-018 Accepted slice with in_first=0: written to field idx; idx increments.
REQ-019 Slice 0 does not require in_first; idx=0 accepts either.
REQ-020 On acceptance of the slice at idx=NIB-1: the completed word (that slice included) and in_cout load into out_data/out_carry; out_valid=1 next cycle; idx wraps to 0; state becomes HOLD.
REQ-021 Latency: final slice accepted in cycle t -> out_valid=1 in cycle t+1.
REQ-022 in_cout of non-final slices is ignored.
REQ-023 in_ready=0 only when idx=NIB-1 (or in_first=0 at idx=NIB-1 is pending) && out_valid=1 && out_ready=0; otherwise in_ready=1, so slices 0..NIB-2 of the next word collect while HOLD.
REQ-024 Exception: in_first=1 at idx=NIB-1 is accepted regardless of out_ready (it does not complete a word).
REQ-025 Simultaneous output drain and final-slice acceptance: new word loads, out_valid stays 1, no bubble.
REQ-026 Output drain without new completion: out_valid=0 next cycle, state COLLECT.
REQ-027 out_data/out_carry remain stable while out_valid=1 && out_ready=0.
REQ-028 word_cnt increments on each output handshake and wraps 255 -> 0.
REQ-029 in_valid=0 leaves idx and the collect register unchanged.

Reset
REQ-030 While rst=1: idx=0, state COLLECT, out_valid=0, out_data=0, out_carry=0, sync_err=0, word_cnt=0, collect register=0; in_ready=1.
REQ-031 Reset asserted mid-word discards the partial word without a sync_err pulse; first slice after release is treated as slice 0.

Verification
REQ-032 NIB=4, out_ready=1; slices 0x5,0xA,0x3,0xC (last in_cout=1) on four consecutive cycles -> next cycle out_valid=1, out_data=0xC3A5, out_carry=1, word_cnt becomes 1 after handshake.
REQ-033 out_ready=0 after word 0xC3A5; send 0x1,0x2,0x3 then 0x4 -> first three accepted, in_ready=0 on 0x4 and out_data stays 0xC3A5; raise out_ready -> 0x4 accepted same cycle, next out_data=0x4321, out_valid never drops.
REQ-034 Send 0x7,0x8 then 0x9 with in_first=1, then 0xA,0xB,0xC -> one sync_err pulse; out_data=0xCBA9.
REQ-035 Assert rst after two slices of a word, release, send 0xF,0xE,0xD,0x0 (last cout=0) -> out_data=0x0DEF, out_carry=0, sync_err never pulses.
REQ-036 Deliver 256 words with continuous out_ready -> word_cnt wraps to 0; back-to-back words show one out_valid word per NIB input cycles with no drops.

Source files
------------

// File: rtl/bc_sum_assembler.sv
// rtl/bc_sum_assembler.sv - assembles NIB 4-bit adder slices (LSB first) into one word with carry-out
// Holds one completed word in an output slot while the next word's lower slices keep collecting.
module bc_sum_assembler #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_cout,
  input  logic             in_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*NIB-1:0] out_data,
  output logic             out_carry,
  output logic             sync_err,
  output logic [7:0]       word_cnt
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [4*NIB-1:0] collect, collect_nxt, word;
  logic             at_last, accept, completes, drain;

  assign out_valid = (state == HOLD);

  always_comb begin
    at_last     = (idx == LAST);
    // Only a word-completing slice must wait for the output slot; a resync slice never completes one.
    in_ready    = !(at_last && !(in_valid && in_first) && out_valid && !out_ready);
    accept      = in_valid && in_ready;
    completes   = accept && !in_first && at_last;
    drain       = out_valid && out_ready;
    word        = collect;
    word[4*(NIB-1) +: 4] = in_sum;
    collect_nxt = collect;
    idx_nxt     = idx;
    if (accept) begin
      if (in_first) begin
        collect_nxt[3:0] = in_sum;
        idx_nxt          = IW'(1);
      end else if (at_last) begin
        idx_nxt = '0;
      end else begin
        collect_nxt[4*idx +: 4] = in_sum;
        idx_nxt                 = idx + 1'b1;
      end
    end
    state_nxt = state;
    if (completes) begin
      state_nxt = HOLD;
    end else if (drain) begin
      state_nxt = COLLECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      idx       <= '0;
      collect   <= '0;
      out_data  <= '0;
      out_carry <= 1'b0;
      sync_err  <= 1'b0;
      word_cnt  <= 8'd0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      collect  <= collect_nxt;
      sync_err <= accept && in_first && (idx != '0);
      if (completes) begin
        out_data  <= word;
        out_carry <= in_cout;
      end
      if (drain) begin
        word_cnt <= word_cnt + 8'd1;
      end
    end
  end

endmodule
